// File: rtl/challenge_pkg.sv
// Shared types and helpers for the adder challenge checker.
package challenge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_VEC = 3'd7;
  localparam logic [3:0] ERR_MAX  = 4'd8;

  // Expected adder response: number of ones in the 3-bit stimulus.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expire is high in the last cycle of the settle window.
module settle_timer #(
  parameter int unsigned CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(CYCLES);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expire_c = (count == CW'(1));

endmodule

// File: rtl/challenge_checker.sv
// Walks all eight 3-bit vectors through an external adder and tallies mismatches.
module challenge_checker
  import challenge_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] sw_out,
  input  logic [1:0] led_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec
);

  state_t     state, state_d;
  logic [2:0] idx, idx_d, sw_d, fail_d;
  logic [3:0] err_d, err_upd;
  logic       busy_d, done_d, pass_d;
  logic       load_c, expire_c, mismatch_c;

  settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .expire_c (expire_c)
  );

  // Case-inequality so an undriven or X response counts as a failure.
  assign mismatch_c = (led_in !== popcount3(sw_out));

  always_comb begin
    state_d = state;
    idx_d   = idx;
    sw_d    = sw_out;
    err_d   = err_count;
    err_upd = err_count;
    fail_d  = fail_vec;
    done_d  = done;
    pass_d  = pass;
    load_c  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = 3'd0;
          sw_d    = 3'd0;
          err_d   = 4'd0;
          fail_d  = 3'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        load_c  = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (expire_c) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch_c) begin
          if (err_count == 4'd0) fail_d = sw_out;
          if (err_count < ERR_MAX) err_upd = err_count + 4'd1;
        end
        err_d = err_upd;
        if (idx == LAST_VEC) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_upd == 4'd0);
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx + 3'd1;
          sw_d    = idx + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      sw_out    <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 4'd0;
      fail_vec  <= 3'd0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      sw_out    <= sw_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
      fail_vec  <= fail_d;
    end
  end

endmodule

// File: tb/tb_challenge_checker.sv
// Self-checking bench: a response table stands in for the adder under test.
module tb_challenge_checker;

  localparam int unsigned SETTLE = 4;
  localparam int PER     = SETTLE + 2;
  localparam int DONE_AT = 8 * PER + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] sw_out, fail_vec;
  logic [1:0] led_in;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [1:0] resp [8];

  int checks = 0;
  int errors = 0;

  challenge_checker #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sw_out    (sw_out),
    .led_in    (led_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;

  always_comb led_in = resp[sw_out];

  task automatic set_correct();
    for (int v = 0; v < 8; v++) resp[v] = 2'($countones(3'(v)));
  endtask

  // Reference: a vector fails when the table answer differs from its bit count.
  task automatic model(output int n, output logic [2:0] first);
    logic [1:0] exp_v;
    n = 0;
    first = 3'd0;
    for (int v = 0; v < 8; v++) begin
      exp_v = 2'($countones(3'(v)));
      if (resp[v] !== exp_v) begin
        if (n == 0) first = 3'(v);
        n++;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({sw_out, busy, done, pass, err_count, fail_vec} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", {sw_out, busy, done, pass, err_count, fail_vec});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL no_autostart busy=%b done=%b required 0 0", busy, done);
      end
    end
  endtask

  // One full run from the start pulse; repulse_at > 0 re-asserts start at that edge.
  task automatic test_run(input string name, input int repulse_at);
    int n;
    logic [2:0] first;
    int exp_sw;
    model(n, first);
    pulse_start();
    for (int c = 1; c <= DONE_AT; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1) begin
        checks++;
        if (err_count !== 4'd0 || fail_vec !== 3'd0 || pass !== 1'b0) begin
          errors++;
          $display("FAIL %s start_clear err=%0d fail_vec=%0d pass=%b required 0 0 0", name, err_count, fail_vec, pass);
        end
      end
      if (c < DONE_AT) begin
        exp_sw = (c - 1) / PER;
        checks++;
        if (sw_out !== 3'(exp_sw)) begin
          errors++;
          $display("FAIL %s sw_out cycle %0d got %0d required %0d", name, c, sw_out, exp_sw);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_done cycle %0d got %b%b required 10", name, c, busy, done);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_at_%0d done=%b busy=%b required 1 0", name, c, done, busy);
        end
        checks++;
        if (pass !== (n == 0)) begin
          errors++;
          $display("FAIL %s pass got %b required %b", name, pass, (n == 0));
        end
        checks++;
        if (err_count !== 4'(n)) begin
          errors++;
          $display("FAIL %s err_count got %0d required %0d", name, err_count, n);
        end
        checks++;
        if (fail_vec !== first) begin
          errors++;
          $display("FAIL %s fail_vec got %0d required %0d", name, fail_vec, first);
        end
      end
      if (c == repulse_at - 1) start = 1'b1;
      if (c == repulse_at) start = 1'b0;
    end
  endtask

  task automatic test_done_hold();
    logic exp_pass;
    exp_pass = pass;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || sw_out !== 3'd7) begin
        errors++;
        $display("FAIL done_hold done=%b busy=%b pass=%b sw_out=%0d required 1 0 %b 7", done, busy, pass, sw_out, exp_pass);
      end
    end
  endtask

  task automatic test_midrun_reset();
    set_correct();
    resp[5] = 2'd0;
    pulse_start();
    repeat (24) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_out, busy, done, pass, err_count, fail_vec} !== 15'd0) begin
      errors++;
      $display("FAIL midrun_reset got %h required 0", {sw_out, busy, done, pass, err_count, fail_vec});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sw_out !== 3'd0) begin
        errors++;
        $display("FAIL post_reset_idle busy=%b done=%b sw_out=%0d required 0 0 0", busy, done, sw_out);
      end
    end
    set_correct();
    test_run("post_reset_run", 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int v = 0; v < 8; v++) begin
        if ($urandom_range(0, 1) == 0) resp[v] = 2'($countones(3'(v)));
        else resp[v] = 2'($urandom_range(0, 3));
      end
      test_run($sformatf("random_%0d", it), 0);
    end
  endtask

  initial begin
    set_correct();
    test_reset();
    test_run("clean", 0);
    test_done_hold();
    for (int v = 0; v < 8; v++) resp[v] = 2'b00;
    test_run("stuck_zero", 0);
    set_correct();
    resp[7] = 2'b10;
    test_run("vec7_fault", 0);
    for (int v = 0; v < 8; v++) resp[v] = 2'($countones(3'(v)) + 1);
    test_run("all_wrong", 0);
    set_correct();
    test_run("repulse", 20);
    test_random();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
